int_to_float_unit: RTL

//  Multi-cycle converter from a 32-bit integer (signed or unsigned) to an IEEE-754

---
 rtl/int_to_float_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/int_to_float_unit.sv
// int_to_float_unit: multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// Define ITOF_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module int_to_float_unit #(
    parameter int NORM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Exponent of a magnitude whose leading one already sits in bit 31 (127 + 31).
    localparam logic [7:0] EXP_TOP  = 8'd158;
    localparam logic [7:0] EXP_STEP = 8'(NORM_STEP);

    state_t      state_r;
    state_t      state_s;
    logic        sign_r;
    logic        sign_s;
    logic [31:0] mag_r;
    logic [31:0] mag_s;
    logic [7:0]  exp_r;
    logic [7:0]  exp_s;
    logic [31:0] out_data_s;
    logic        out_valid_s;
    logic        round_up_s;
    logic [30:0] packed_s;
    logic        coarse_ok_s;

`ifdef ITOF_RNE_EN
    assign round_up_s = mag_r[7] & ((|mag_r[6:0]) | mag_r[8]);
`else
    assign round_up_s = 1'b0;
`endif

    // A carry out of the fraction rolls into the exponent for free in this sum.
    assign packed_s    = {exp_r, mag_r[30:8]} + {30'd0, round_up_s};
    assign coarse_ok_s = (mag_r[31 -: NORM_STEP] == {NORM_STEP{1'b0}});

    // Next-state, datapath and output computation for the three-state sequencer.
    always_comb begin
        state_s     = state_r;
        sign_s      = sign_r;
        mag_s       = mag_r;
        exp_s       = exp_r;
        out_data_s  = out_data;
        out_valid_s = out_valid;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_data == 32'd0) begin
                        out_data_s  = 32'd0;
                        out_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        sign_s  = in_signed & in_data[31];
                        mag_s   = (in_signed && in_data[31]) ? (32'd0 - in_data) : in_data;
                        exp_s   = EXP_TOP;
                        state_s = ST_NORM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (mag_r[31]) begin
                    out_data_s  = {sign_r, packed_s};
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else if (coarse_ok_s) begin
                    mag_s = mag_r << NORM_STEP;
                    exp_s = exp_r - EXP_STEP;
                end else begin
                    mag_s = mag_r << 1;
                    exp_s = exp_r - 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= 32'd0;
            exp_r     <= 8'd0;
            out_data  <= 32'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            sign_r    <= sign_s;
            mag_r     <= mag_s;
            exp_r     <= exp_s;
            out_data  <= out_data_s;
            out_valid <= out_valid_s;
            in_ready  <= (state_s == ST_IDLE);
            busy      <= (state_s != ST_IDLE);
        end
    end

endmodule
